// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit multiply/divide unit feeding a Hi/Lo register file.
//
// Ports
//   Clk        in   sole clock, rising edge
//   Rst        in   asynchronous active-high reset
//   Start      in   request pulse, accepted only when not Busy
//   Op[1:0]    in   00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//   A[31:0]    in   multiplicand / dividend
//   B[31:0]    in   multiplier / divisor
//   Busy       out  high in CALC and FIX
//   Done       out  one-cycle result strobe (Hi/Lo write enable)
//   HiOut      out  product[63:32] or remainder
//   LoOut      out  product[31:0] or quotient
//   DivByZero  out  set with the results of a DIV/DIVU whose divisor was zero
//   dbg_state  out  current FSM state, for checkers
//
// Handshake: Start is sampled on a rising edge while Busy=0 (IDLE or DONE);
// operands are captured on that edge and never looked at again. The results
// appear with Done=1 exactly 34 edges later and hold until the next operation
// rewrites them.
module mul_div_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        DivByZero,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic        fix_phase;
  logic [5:0]  count;
  logic [1:0]  op_q;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;

  logic        is_div;
  logic        start_ok;
  logic        in_signed;
  logic [31:0] a_in_mag;
  logic [31:0] b_in_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ok;
  logic [63:0] prod_neg;
  logic        dbz;

  assign Busy      = (state == CALC) || (state == FIX);
  assign Done      = (state == DONE);
  assign dbg_state = state;

  assign is_div    = op_q[1];
  assign start_ok  = Start && ((state == IDLE) || (state == DONE));
  assign in_signed = ~Op[0];
  assign a_in_mag  = (in_signed && A[31]) ? -A : A;
  assign b_in_mag  = (in_signed && B[31]) ? -B : B;

  // Multiply step: add multiplicand into the high half when the current
  // multiplier bit (acc_lo[0]) is set, then shift the 64-bit pair right.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : 33'd0);

  // Restoring divide step: acc_hi is the partial remainder, acc_lo shifts the
  // dividend out at the top and the quotient bits in at the bottom. The
  // remainder stays below the divisor, so a 33-bit difference carries the
  // borrow in bit 32.
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_diff  = div_shift - {1'b0, b_mag};
  assign div_ok    = ~div_diff[32];

  assign prod_neg  = -{acc_hi, acc_lo};
  assign dbz       = is_div && (b_mag == 32'd0);

  // FIX is two cycles: phase 0 applies the sign correction to the
  // accumulator, phase 1 loads the output registers. This keeps the 64-bit
  // negate out of the output load path and sets the 34-edge latency.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      fix_phase <= 1'b0;
      count     <= 6'd0;
      op_q      <= 2'd0;
      a_mag     <= 32'd0;
      b_mag     <= 32'd0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      acc_hi    <= 32'd0;
      acc_lo    <= 32'd0;
      HiOut     <= 32'd0;
      LoOut     <= 32'd0;
      DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            op_q   <= Op;
            a_mag  <= a_in_mag;
            b_mag  <= b_in_mag;
            sign_a <= in_signed && A[31];
            sign_b <= in_signed && B[31];
            acc_hi <= 32'd0;
            // Multiply shifts the multiplier through acc_lo; divide shifts
            // the dividend through it.
            acc_lo <= Op[1] ? a_in_mag : b_in_mag;
            count  <= 6'd0;
            state  <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (is_div) begin
            acc_hi <= div_ok ? div_diff[31:0] : div_shift[31:0];
            acc_lo <= {acc_lo[30:0], div_ok};
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
          end
          count <= count + 6'd1;
          if (count == 6'd31) begin
            state     <= FIX;
            fix_phase <= 1'b0;
          end
        end
        FIX: begin
          if (!fix_phase) begin
            if (!is_div) begin
              if (sign_a ^ sign_b) {acc_hi, acc_lo} <= prod_neg;
            end else begin
              // Truncating division: quotient takes signA^signB, remainder
              // takes the dividend's sign.
              if (sign_a ^ sign_b) acc_lo <= -acc_lo;
              if (sign_a)          acc_hi <= -acc_hi;
            end
            fix_phase <= 1'b1;
          end else begin
            if (dbz) begin
              // Hi gets the original dividend back (magnitude re-signed).
              HiOut     <= sign_a ? -a_mag : a_mag;
              LoOut     <= 32'hFFFF_FFFF;
              DivByZero <= 1'b1;
            end else begin
              HiOut     <= acc_hi;
              LoOut     <= acc_lo;
              DivByZero <= 1'b0;
            end
            fix_phase <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
